// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with strobe/response handshake, no-answer timeout and alarm
module bus_arbiter #(
    parameter logic [7:0] ALARM_DLY_TICKS = 8'd250,
    parameter logic [1:0] ALARM_TICKS = 2'd3
) (
    input  logic        clk_sys,
    input  logic        clm,
    input  logic [0:3]  req,
    input  logic [0:11] cmd,
    output logic [0:3]  gnt,
    output logic [0:3]  done,
    output logic [1:0]  status,
    output logic        dw,
    output logic        dr,
    output logic        ds,
    output logic        df,
    output logic        din,
    input  logic        rok,
    input  logic        ren,
    input  logic        rpe,
    output logic        alarm,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, ALARM} state_t;
    state_t state_q, state_d;
    logic [0:3] gnt_q, gnt_d, done_q, done_d;
    logic [1:0] status_q, status_d, rr_q, rr_d, own_q, own_d, pick, fin_st;
    logic [2:0] cmd_q, cmd_d;
    logic [4:0] stb_q, stb_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       alarm_q, alarm_d, rsp, fin;

    always_comb begin
        pick = rr_q;
        for (int k = 3; k >= 0; k--)
            pick = req[2'(rr_q + 2'(k))] ? 2'(rr_q + 2'(k)) : pick;
    end

    assign rsp = rok | ren | rpe;
    assign cnt_inc = (cnt_q == ALARM_DLY_TICKS) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        done_d = '0;
        status_d = status_q;
        rr_d = rr_q;
        own_d = own_q;
        cmd_d = cmd_q;
        stb_d = stb_q;
        cnt_d = cnt_q;
        alarm_d = 1'b0;
        fin = 1'b0;
        fin_st = 2'b11;
        case (state_q)
            IDLE: if (|req) begin
                own_d = pick;
                cmd_d = cmd[3*pick +: 3];
                gnt_d = '0;
                gnt_d[pick] = 1'b1;
                state_d = SETUP;
            end
            SETUP: if (cmd_q > 3'd4) fin = 1'b1;
            else begin
                stb_d = 5'd1 << cmd_q;
                cnt_d = '0;
                state_d = STROBE;
            end
            STROBE: begin
                cnt_d = cnt_inc;
                if (rsp) begin
                    status_d = rpe ? 2'b10 : ren ? 2'b01 : 2'b00;
                    stb_d = '0;
                    state_d = RELEASE;
                end else if (cnt_inc == ALARM_DLY_TICKS) begin
                    stb_d = '0;
                    cnt_d = '0;
                    alarm_d = 1'b1;
                    state_d = ALARM;
                end
            end
            RELEASE: begin
                cnt_d = cnt_inc;
                fin = !rsp;
                fin_st = status_q;
                if (rsp && cnt_inc == ALARM_DLY_TICKS) begin
                    cnt_d = '0;
                    alarm_d = 1'b1;
                    state_d = ALARM;
                end
            end
            ALARM: begin
                cnt_d = cnt_q + 8'd1;
                fin = cnt_q == {6'd0, ALARM_TICKS - 2'd1};
                alarm_d = !fin;
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            done_d[own_q] = 1'b1;
            status_d = fin_st;
            gnt_d = '0;
            rr_d = own_q + 2'd1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (clm) begin
            state_q <= IDLE;
            gnt_q <= '0;
            done_q <= '0;
            status_q <= '0;
            rr_q <= '0;
            own_q <= '0;
            cmd_q <= '0;
            stb_q <= '0;
            cnt_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            done_q <= done_d;
            status_q <= status_d;
            rr_q <= rr_d;
            own_q <= own_d;
            cmd_q <= cmd_d;
            stb_q <= stb_d;
            cnt_q <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign gnt = gnt_q;
    assign done = done_q;
    assign status = status_q;
    assign {din, df, ds, dr, dw} = stb_q;
    assign alarm = alarm_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios with a completion scoreboard for bus_arbiter
module tb_bus_arbiter;
    logic        clk_sys = 1'b0, clm = 1'b1, rok = 1'b0, ren = 1'b0, rpe = 1'b0;
    logic [0:3]  req = '0;
    logic [0:11] cmd = '0;
    logic [0:3]  gnt, done;
    logic [1:0]  status;
    logic        dw, dr, ds, df, din, alarm, busy;
    logic [4:0]  stb;
    int          checks = 0, errors = 0, viol = 0;
    typedef struct {logic [0:3] d; logic [1:0] st;} exp_t;
    exp_t        sb[$];

    bus_arbiter dut (
        .clk_sys(clk_sys), .clm(clm), .req(req), .cmd(cmd), .gnt(gnt), .done(done),
        .status(status), .dw(dw), .dr(dr), .ds(ds), .df(df), .din(din),
        .rok(rok), .ren(ren), .rpe(rpe), .alarm(alarm), .busy(busy)
    );

    assign stb = {din, df, ds, dr, dw};
    always #5 clk_sys = ~clk_sys;
    always @(negedge clk_sys)
        if (!$onehot0(gnt) || !$onehot0(stb)) viol++;

    function automatic logic [0:11] mk(input logic [2:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_stb(input int max);
        for (int i = 0; i < max && stb == 0; i++) tick();
    endtask

    task automatic wait_done(input int max);
        exp_t e;
        for (int i = 0; i < max && done == 0; i++) tick();
        e = sb.pop_front();
        chk("done_vec", 32'(done), 32'(e.d));
        chk("done_status", 32'(status), 32'(e.st));
        chk("gnt_drop", 32'(gnt), 0);
        tick();
        chk("done_pulse", 32'(done), 0);
    endtask

    initial begin
        logic [0:3] g;
        logic       acc;
        int         n;
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_outs", 32'({done, status, stb, alarm, busy}), 0);
        clm = 1'b0;

        req = 4'b1000; cmd = mk(3'd1, 3'd0, 3'd0, 3'd0);
        sb.push_back('{4'b1000, 2'b00});
        tick();
        chk("t1_gnt", 32'(gnt), 32'(4'b1000));
        chk("t1_setup_stb", 32'(stb), 0);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        tick();
        chk("t1_dr", 32'(stb), 32'(5'b00010));
        repeat (5) tick();
        rok = 1'b1;
        tick();
        chk("t1_rel_stb", 32'(stb), 0);
        repeat (2) tick();
        chk("t1_hold", 32'(done), 0);
        rok = 1'b0;
        wait_done(5);

        req = 4'b0001; cmd = mk(3'd0, 3'd0, 3'd0, 3'd1);
        tick();
        chk("c_gnt", 32'(gnt), 32'(4'b0001));
        tick();
        chk("c_dr", 32'(stb), 32'(5'b00010));
        req = '0;
        repeat (3) tick();
        clm = 1'b1;
        tick();
        clm = 1'b0;
        chk("c_clear", 32'({gnt, done, status, stb, alarm, busy}), 0);
        acc = 1'b0;
        repeat (3) begin tick(); acc |= |done; end
        chk("c_nodone", 32'(acc), 0);

        req = 4'b1111; cmd = '0;
        for (int k = 0; k < 5; k++) begin
            g = 4'b1000 >> (k % 4);
            sb.push_back('{g, 2'b00});
            wait_stb(6);
            chk("rr_gnt", 32'(gnt), 32'(g));
            chk("rr_dw", 32'(stb), 1);
            rok = 1'b1;
            tick();
            rok = 1'b0;
            if (k == 4) req = '0;
            wait_done(5);
        end

        req = 4'b0100; cmd = mk(3'd0, 3'd3, 3'd0, 3'd0);
        sb.push_back('{4'b0100, 2'b11});
        tick();
        chk("t3_gnt", 32'(gnt), 32'(4'b0100));
        req = '0;
        wait_stb(3);
        n = 0; acc = 1'b0;
        while (df && n < 300) begin acc |= ds; n++; tick(); end
        chk("t3_df_len", 32'(n), 250);
        chk("t3_ds_low", 32'(acc), 0);
        n = 0;
        while (alarm && n < 10) begin n++; tick(); end
        chk("t3_alarm_len", 32'(n), 3);
        wait_done(2);

        req = 4'b0010; cmd = mk(3'd0, 3'd0, 3'd1, 3'd0);
        sb.push_back('{4'b0010, 2'b10});
        tick();
        req = '0;
        wait_stb(3);
        chk("t4_dr", 32'(stb), 32'(5'b00010));
        rpe = 1'b1; rok = 1'b1;
        tick();
        rpe = 1'b0;
        chk("t4_stb_drop", 32'(stb), 0);
        acc = 1'b0;
        repeat (10) begin tick(); acc |= |done; end
        chk("t4_wait_rok", 32'(acc), 0);
        rok = 1'b0;
        wait_done(3);

        req = 4'b1000; cmd = mk(3'd6, 3'd0, 3'd0, 3'd0);
        sb.push_back('{4'b1000, 2'b11});
        tick();
        chk("t5_gnt", 32'(gnt), 32'(4'b1000));
        req = '0;
        tick();
        chk("t5_done_now", 32'(done), 32'(4'b1000));
        chk("t5_no_stb", 32'(stb), 0);
        wait_done(1);

        req = 4'b0100; cmd = mk(3'd0, 3'd2, 3'd0, 3'd0); rok = 1'b1;
        sb.push_back('{4'b0100, 2'b00});
        tick();
        req = '0;
        tick();
        rok = 1'b0;
        chk("t7_ds", 32'(stb), 32'(5'b00100));
        repeat (249) tick();
        chk("t7_ds_last", 32'(stb), 32'(5'b00100));
        rok = 1'b1;
        tick();
        rok = 1'b0;
        chk("t7_no_alarm", 32'(alarm), 0);
        chk("t7_stb_drop", 32'(stb), 0);
        wait_done(3);

        chk("onehot", 32'(viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
